// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared definitions for the UART serial-to-parallel frame
//                receiver: FSM state encoding, parity helper and parameter
//                legality check.
//  Contents    : sipo_state_e  - receiver FSM states
//                parity_of()   - parity bit a transmitter would send
//                params_legal()- elaboration-time parameter range check
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    localparam int c_data_w_min    = 5;
    localparam int c_data_w_max    = 9;
    localparam int c_stop_bits_min = 1;
    localparam int c_stop_bits_max = 2;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_PARITY = 2'd1,
        ST_STOP   = 2'd2
    } sipo_state_e;

    // Parity bit that a transmitter would append to 'data'. Narrower words
    // must be zero-extended by the caller; zero padding does not change the
    // XOR reduction.
    function automatic logic parity_of(
        input logic [c_data_w_max-1:0] data,
        input logic                    odd
    );
        return (^data) ^ odd;
    endfunction

    function automatic bit params_legal(input int data_w, input int stop_bits);
        return (data_w    >= c_data_w_min)    && (data_w    <= c_data_w_max) &&
               (stop_bits >= c_stop_bits_min) && (stop_bits <= c_stop_bits_max);
    endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_frame_rx_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shreg
//  Description : DATA_W-wide receive shift register. With LSB_FIRST=1 the
//                register shifts right and new bits enter the MSB, so after
//                DATA_W shifts the first bit lands in bit 0. With LSB_FIRST=0
//                it shifts left and new bits enter the LSB, so the first bit
//                lands in bit DATA_W-1.
//  Ports       : clk      - clock
//                rst      - asynchronous active-high reset
//                clr      - synchronous clear (has priority over shift_en)
//                shift_en - shift data_in in this cycle
//                data_in  - serial bit
//                q        - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_shreg #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              data_in,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    if (LSB_FIRST != 0) begin : g_lsb_first
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (clr) begin
                r_q <= '0;
            end else if (shift_en) begin
                r_q <= {data_in, r_q[DATA_W-1:1]};
            end
        end
    end else begin : g_msb_first
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (clr) begin
                r_q <= '0;
            end else if (shift_en) begin
                r_q <= {r_q[DATA_W-2:0], data_in};
            end
        end
    end

    assign q = r_q;

endmodule : sipo_shreg
`default_nettype wire

// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_rx
//  Description : Serial-to-parallel UART frame receiver. Assembles DATA_W
//                data bits, an optional parity bit and 1..2 stop bits from
//                per-bit strobes, then presents the word with parity/framing
//                status on a valid/ready handshake. A completed frame that
//                cannot be handed over is dropped and flagged by a one-cycle
//                overrun pulse.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                data_in       - sampled serial bit (valid with data_shift)
//                data_shift    - one strobe per bit after the start bit
//                frame_start   - start-bit pulse, aborts any partial frame
//                sipo_out      - received data word
//                rx_valid      - sipo_out / parity_err / frame_err valid
//                rx_ready      - consumer accepts word on valid && ready
//                parity_err    - parity mismatch of the held frame
//                frame_err     - a stop bit of the held frame sampled 0
//                overrun       - one-cycle pulse, completed frame dropped
//                sipo_count    - bits received in the current frame
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  LSB_FIRST  = 1,
    parameter int  PARITY_EN  = 0,
    parameter int  PARITY_ODD = 0,
    parameter int  STOP_BITS  = 1,
    localparam int FRAME_BITS = DATA_W + PARITY_EN + STOP_BITS,
    localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic              data_shift,
    input  logic              frame_start,
    output logic [DATA_W-1:0] sipo_out,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  sipo_count
);

    if (!params_legal(DATA_W, STOP_BITS)) begin : g_bad_params
        $error("sipo_frame_rx: DATA_W must be 5..9 and STOP_BITS 1..2");
    end

    localparam logic [CNT_W-1:0] c_last_data = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(FRAME_BITS - 1);
    localparam logic             c_par_en    = (PARITY_EN != 0);
    localparam logic             c_par_odd   = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // Frame assembly state
    // ------------------------------------------------------------------
    sipo_state_e       r_state;
    sipo_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_par_acc;      // parity error of the frame in progress
    logic              w_par_acc_nxt;
    logic              r_stop_acc;     // any stop bit so far sampled 0
    logic              w_stop_acc_nxt;

    logic              w_shreg_clr;
    logic              w_shreg_en;
    logic [DATA_W-1:0] w_shreg_q;
    logic [c_data_w_max-1:0] w_par_data;

    logic              w_frame_done;
    logic              w_frame_perr;
    logic              w_frame_ferr;

    // ------------------------------------------------------------------
    // Output / handshake registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_sipo_out;
    logic              r_rx_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_accept;

    sipo_shreg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_shreg_clr),
        .shift_en (w_shreg_en),
        .data_in  (data_in),
        .q        (w_shreg_q)
    );

    // Zero-extend the data word for the package parity helper.
    always_comb begin
        w_par_data               = '0;
        w_par_data[DATA_W-1:0]   = w_shreg_q;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_DATA;
            r_count    <= '0;
            r_par_acc  <= 1'b0;
            r_stop_acc <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_par_acc  <= w_par_acc_nxt;
            r_stop_acc <= w_stop_acc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and frame-completion decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_par_acc_nxt  = r_par_acc;
        w_stop_acc_nxt = r_stop_acc;
        w_shreg_clr    = 1'b0;
        w_shreg_en     = 1'b0;
        w_frame_done   = 1'b0;
        w_frame_perr   = c_par_en & r_par_acc;
        w_frame_ferr   = r_stop_acc;

        if (frame_start) begin
            // Start bit wins over a coincident strobe: restart the frame.
            w_state_nxt    = ST_DATA;
            w_count_nxt    = '0;
            w_par_acc_nxt  = 1'b0;
            w_stop_acc_nxt = 1'b0;
            w_shreg_clr    = 1'b1;
        end else if (data_shift) begin
            w_count_nxt = r_count + CNT_W'(1);
            case (r_state)
                ST_DATA: begin
                    w_shreg_en = 1'b1;
                    if (r_count == c_last_data) begin
                        w_state_nxt = c_par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    // Data bits are complete in the shift register here.
                    w_par_acc_nxt = parity_of(w_par_data, c_par_odd) ^ data_in;
                    w_state_nxt   = ST_STOP;
                end
                ST_STOP: begin
                    w_stop_acc_nxt = r_stop_acc | ~data_in;
                    if (r_count == c_last_bit) begin
                        w_frame_done   = 1'b1;
                        w_frame_ferr   = r_stop_acc | ~data_in;
                        w_state_nxt    = ST_DATA;
                        w_count_nxt    = '0;
                        w_par_acc_nxt  = 1'b0;
                        w_stop_acc_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_DATA;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // A new frame may be loaded if nothing is held, or the held word is
    // being taken on this very edge.
    assign w_accept = ~r_rx_valid | rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sipo_out   <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done && w_accept) begin
                r_sipo_out   <= w_shreg_q;
                r_parity_err <= w_frame_perr;
                r_frame_err  <= w_frame_ferr;
                r_rx_valid   <= 1'b1;
            end else begin
                if (w_frame_done) begin
                    r_overrun <= 1'b1;
                end
                if (r_rx_valid && rx_ready) begin
                    r_rx_valid <= 1'b0;
                end
            end
        end
    end

    assign sipo_out   = r_sipo_out;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign sipo_count = r_count;

endmodule : sipo_frame_rx
`default_nettype wire
